// File: rtl/instr_prefetch_unit.sv
// Prefetching instruction fetch stage.
// Owns the fetch PC, issues sequential reads to a 1-cycle-latency synchronous
// instruction memory and buffers the returned words in a DEPTH-entry FIFO that
// presents {pc, instr} to decode. A redirect flushes the FIFO, squashes the
// in-flight read and restarts fetch at the aligned redirect PC.
//
// Handshake: the head is offered when instr_valid=1; it is consumed in any
// cycle where instr_valid && instr_ready are both high at the rising clock
// edge. While instr_valid=1 and instr_ready=0 the head (instr, instr_pc) is
// held stable. The memory side has no backpressure: every mem_req is answered
// by mem_rdata in the following cycle.
module instr_prefetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    mem_req,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic                    redirect_valid,
    input  logic [ADDR_W-1:0]       redirect_pc,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [DATA_W-1:0]       instr,
    output logic [ADDR_W-1:0]       instr_pc,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Clears the low log2(PC_STEP) bits of a redirect target.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(PC_STEP - 1));
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);

    // Fetch state
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] tag_pc;
    logic              inflight;

    // FIFO state
    logic [ADDR_W-1:0] fifo_pc    [DEPTH];
    logic [DATA_W-1:0] fifo_instr [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    // Control
    logic              push;
    logic              pop;
    logic              issue;
    logic              head_present;
    logic [CW:0]       occupancy;
    logic [CW:0]       limit;

    assign head_present = (count != '0);

    // A redirect hides the head so decode never consumes a stale entry.
    assign instr_valid = head_present && !redirect_valid;
    assign pop         = instr_valid && instr_ready;

    // Returned data is dropped in the redirect cycle (squashed read).
    assign push = inflight && !redirect_valid;

    // Entries already held plus the one still in flight must leave room for
    // the new read; a pop in this cycle frees one slot early.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign limit     = (CW+1)'(DEPTH) + {{CW{1'b0}}, pop};

    assign issue    = !rst && !redirect_valid && (occupancy < limit);
    assign mem_req  = issue;
    assign mem_addr = fetch_pc;

    // Head outputs read as zero while the FIFO is empty (including in reset).
    assign instr      = head_present ? fifo_instr[rd_ptr] : '0;
    assign instr_pc   = head_present ? fifo_pc[rd_ptr]    : '0;
    assign fifo_count = count;

    // Fetch PC sequencing, in-flight flag and tag of the outstanding read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            tag_pc   <= '0;
            inflight <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ALIGN_MASK;
            inflight <= 1'b0;
        end else if (issue) begin
            fetch_pc <= fetch_pc + STEP;
            tag_pc   <= fetch_pc;
            inflight <= 1'b1;
        end else begin
            inflight <= 1'b0;
        end
    end

    // FIFO pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: capture {tag_pc, mem_rdata} for the returning read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= tag_pc;
            fifo_instr[wr_ptr] <= mem_rdata;
        end
    end

    // Credit accounting must never let a return land on a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == CW'(DEPTH))));

    // A pop can only happen with an entry present.
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && !head_present));

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Self-checking bench for instr_prefetch_unit: directed scenarios for reset,
// streaming, stall/drain, redirect, alignment, PC wrap and mid-stream reset,
// followed by a randomized run checked against a stream-level reference model.
module tb_instr_prefetch_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;

    // Main DUT (RESET_PC = 0)
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [2:0]  fifo_count;

    // Wrap DUT (RESET_PC near the top of the address space)
    logic        w_mem_req;
    logic [31:0] w_mem_addr;
    logic [31:0] w_mem_rdata;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_pc;
    logic        w_instr_valid;
    logic        w_instr_ready;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;
    logic [2:0]  w_fifo_count;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_q[$];

    instr_prefetch_unit #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)
    ) u_dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .fifo_count(fifo_count)
    );

    instr_prefetch_unit #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)
    ) u_dut_w (
        .clk(clk), .rst(rst),
        .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_rdata(w_mem_rdata),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .instr_valid(w_instr_valid), .instr_ready(w_instr_ready),
        .instr(w_instr), .instr_pc(w_instr_pc), .fifo_count(w_fifo_count)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents: word at byte address a is 0x1000 + a/4
    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h1000 + (a >> 2);
    endfunction

    // Synchronous memories with 1-cycle read latency
    always @(posedge clk) begin
        if (mem_req) mem_rdata <= word(mem_addr);
        if (w_mem_req) w_mem_rdata <= word(w_mem_addr);
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Hold reset across two edges; returns at the start of the first cycle with rst=0.
    task automatic do_reset(input logic rdy);
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        instr_ready = rdy;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        w_redirect_valid = 1'b0;
        w_redirect_pc = '0;
        w_instr_ready = 1'b1;
        #2;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({mem_req, instr_valid, fifo_count} !== 5'b0) begin
                n_errors++;
                $display("FAIL reset_ctrl: req=%b valid=%b count=%0d expected 0/0/0", mem_req, instr_valid, fifo_count);
            end
            n_checks++;
            if ({instr, instr_pc} !== 64'h0) begin
                n_errors++;
                $display("FAIL reset_head: instr=%h pc=%h expected 0/0", instr, instr_pc);
            end
            n_checks++;
            if ({w_mem_req, w_instr_valid, w_fifo_count} !== 5'b0) begin
                n_errors++;
                $display("FAIL reset_wrap_ctrl: req=%b valid=%b count=%0d expected 0", w_mem_req, w_instr_valid, w_fifo_count);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'(4 * c)) begin
                n_errors++;
                $display("FAIL stream_req c%0d: req=%b addr=%h expected 1/%h", c, mem_req, mem_addr, 32'(4 * c));
            end
            n_checks++;
            if (instr_valid !== (c >= 2)) begin
                n_errors++;
                $display("FAIL stream_valid c%0d: got %b expected %b", c, instr_valid, (c >= 2));
            end
            if (c >= 2) begin
                n_checks++;
                if (instr_pc !== 32'(4 * (c - 2)) || instr !== 32'(32'h1000 + c - 2)) begin
                    n_errors++;
                    $display("FAIL stream_head c%0d: pc=%h instr=%h expected %h/%h", c, instr_pc, instr, 32'(4 * (c - 2)), 32'(32'h1000 + c - 2));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_stall_drain();
        int exp_cnt;
        do_reset(1'b0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            exp_cnt = (c < 2) ? 0 : ((c - 1 > DEPTH) ? DEPTH : c - 1);
            n_checks++;
            if (fifo_count !== 3'(exp_cnt)) begin
                n_errors++;
                $display("FAIL stall_count c%0d: got %0d expected %0d", c, fifo_count, exp_cnt);
            end
            n_checks++;
            if (mem_req !== (c < 4) || (c < 4 && mem_addr !== 32'(4 * c))) begin
                n_errors++;
                $display("FAIL stall_req c%0d: req=%b addr=%h expected req %b", c, mem_req, mem_addr, (c < 4));
            end
            if (c >= 2) begin
                n_checks++;
                if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h1000) begin
                    n_errors++;
                    $display("FAIL stall_head c%0d: valid=%b pc=%h instr=%h expected 1/0/1000", c, instr_valid, instr_pc, instr);
                end
            end
            next_cycle();
        end
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(32'(4 * i));
        instr_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            logic [31:0] e;
            @(negedge clk);
            e = exp_q.pop_front();
            if (c == 0) begin
                n_checks++;
                if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
                    n_errors++;
                    $display("FAIL drain_resume: req=%b addr=%h expected 1/00000010", mem_req, mem_addr);
                end
            end
            n_checks++;
            if (instr_valid !== 1'b1 || instr_pc !== e || instr !== word(e)) begin
                n_errors++;
                $display("FAIL drain_head c%0d: valid=%b pc=%h instr=%h expected 1/%h/%h", c, instr_valid, instr_pc, instr, e, word(e));
            end
            next_cycle();
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        for (int c = 0; c < 4; c++) next_cycle();
        // Cycle R: three entries buffered and one read in flight
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        @(negedge clk);
        n_checks++;
        if (fifo_count !== 3'd3 || instr_valid !== 1'b0 || mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL redir_R: count=%0d valid=%b req=%b expected 3/0/0", fifo_count, instr_valid, mem_req);
        end
        next_cycle();
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (fifo_count !== 3'd0 || instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h40) begin
            n_errors++;
            $display("FAIL redir_R1: count=%0d valid=%b req=%b addr=%h expected 0/0/1/00000040", fifo_count, instr_valid, mem_req, mem_addr);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (instr_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL redir_R2: valid=%b expected 0", instr_valid);
        end
        next_cycle();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'(32'h40 + 4 * k) || instr !== word(32'(32'h40 + 4 * k))) begin
                n_errors++;
                $display("FAIL redir_stream k%0d: valid=%b pc=%h instr=%h expected pc %h", k, instr_valid, instr_pc, instr, 32'(32'h40 + 4 * k));
            end
            next_cycle();
        end
    endtask

    task automatic test_align_back_to_back();
        // Unaligned target
        redirect_valid = 1'b1;
        redirect_pc = 32'h43;
        @(negedge clk);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
            n_errors++;
            $display("FAIL align_addr: req=%b addr=%h expected 1/00000040", mem_req, mem_addr);
        end
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h40) begin
            n_errors++;
            $display("FAIL align_head: valid=%b pc=%h expected 1/00000040", instr_valid, instr_pc);
        end
        next_cycle();
        // Back-to-back redirects: only the last target is fetched
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        next_cycle();
        redirect_pc = 32'hC0;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_second: req=%b valid=%b expected 0/0", mem_req, instr_valid);
        end
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'hC0) begin
            n_errors++;
            $display("FAIL b2b_addr: req=%b addr=%h expected 1/000000c0", mem_req, mem_addr);
        end
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            @(negedge clk);
            n_checks++;
            if (instr_valid !== (k >= 1) || (k >= 1 && instr_pc !== 32'(32'hC0 + 4 * (k - 1)))) begin
                n_errors++;
                $display("FAIL b2b_stream k%0d: valid=%b pc=%h", k, instr_valid, instr_pc);
            end
        end
        next_cycle();
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr [4];
        exp_addr[0] = 32'hFFFF_FFFC;
        exp_addr[1] = 32'h0;
        exp_addr[2] = 32'h4;
        exp_addr[3] = 32'h8;
        do_reset(1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c < 4) begin
                n_checks++;
                if (w_mem_req !== 1'b1 || w_mem_addr !== exp_addr[c]) begin
                    n_errors++;
                    $display("FAIL wrap_addr c%0d: req=%b addr=%h expected 1/%h", c, w_mem_req, w_mem_addr, exp_addr[c]);
                end
            end
            if (c >= 2) begin
                n_checks++;
                if (w_instr_valid !== 1'b1 || w_instr_pc !== exp_addr[c-2] || w_instr !== word(exp_addr[c-2])) begin
                    n_errors++;
                    $display("FAIL wrap_head c%0d: valid=%b pc=%h instr=%h expected pc %h", c, w_instr_valid, w_instr_pc, w_instr, exp_addr[c-2]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_midstream();
        do_reset(1'b1);
        for (int c = 0; c < 6; c++) next_cycle();
        // A read issued last cycle is in flight; reset lands mid-cycle.
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({mem_req, instr_valid, fifo_count} !== 5'b0 || {instr, instr_pc} !== 64'h0) begin
            n_errors++;
            $display("FAIL midrst_async: req=%b valid=%b count=%0d instr=%h pc=%h expected all 0", mem_req, instr_valid, fifo_count, instr, instr_pc);
        end
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_checks++;
                if (fifo_count !== 3'd0) begin
                    n_errors++;
                    $display("FAIL midrst_stale: count=%0d expected 0", fifo_count);
                end
            end
            if (c >= 2) begin
                n_checks++;
                if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * (c - 2)) || instr !== word(32'(4 * (c - 2)))) begin
                    n_errors++;
                    $display("FAIL midrst_head c%0d: valid=%b pc=%h instr=%h expected pc %h", c, instr_valid, instr_pc, instr, 32'(4 * (c - 2)));
                end
            end
            next_cycle();
        end
    endtask

    // Randomized run: the reference is the architectural stream -- every
    // instruction decode accepts must be the next sequential PC since the
    // last redirect, carrying that PC's memory word.
    task automatic test_random();
        logic [31:0] exp_next_pc;
        logic        prev_hold;
        logic [31:0] prev_pc;
        logic [31:0] prev_instr;
        int          quiet;
        int          npops;
        int          pct;
        exp_next_pc = '0;
        prev_hold = 1'b0;
        prev_pc = '0;
        prev_instr = '0;
        quiet = 0;
        npops = 0;
        pct = 100;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0:       pct = 100;
                    1:       pct = 70;
                    default: pct = 20;
                endcase
            end
            redirect_valid = (cyc == 0) || ($urandom_range(0, 24) == 0);
            redirect_pc = $urandom;
            instr_ready = ($urandom_range(1, 100) <= pct);
            @(negedge clk);
            quiet = redirect_valid ? 0 : quiet + 1;
            if (redirect_valid) begin
                n_checks++;
                if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
                    n_errors++;
                    $display("FAIL rnd_redirect cyc%0d: valid=%b req=%b expected 0/0", cyc, instr_valid, mem_req);
                end
            end
            n_checks++;
            if (fifo_count > 3'(DEPTH)) begin
                n_errors++;
                $display("FAIL rnd_count cyc%0d: got %0d max %0d", cyc, fifo_count, DEPTH);
            end
            if (quiet >= 3) begin
                n_checks++;
                if (instr_valid !== 1'b1) begin
                    n_errors++;
                    $display("FAIL rnd_bubble cyc%0d: valid=%b expected 1", cyc, instr_valid);
                end
            end
            if (prev_hold && instr_valid) begin
                n_checks++;
                if (instr_pc !== prev_pc || instr !== prev_instr) begin
                    n_errors++;
                    $display("FAIL rnd_stable cyc%0d: pc=%h instr=%h expected %h/%h", cyc, instr_pc, instr, prev_pc, prev_instr);
                end
            end
            if (instr_valid && instr_ready) begin
                n_checks++;
                if (instr_pc !== exp_next_pc || instr !== word(exp_next_pc)) begin
                    n_errors++;
                    $display("FAIL rnd_pop cyc%0d: pc=%h instr=%h expected %h/%h", cyc, instr_pc, instr, exp_next_pc, word(exp_next_pc));
                end
                exp_next_pc = exp_next_pc + 32'd4;
                npops++;
            end
            if (redirect_valid) exp_next_pc = redirect_pc & 32'hFFFF_FFFC;
            prev_hold = instr_valid && !instr_ready;
            prev_pc = instr_pc;
            prev_instr = instr;
            next_cycle();
        end
        redirect_valid = 1'b0;
        n_checks++;
        if (npops < 300) begin
            n_errors++;
            $display("FAIL rnd_progress: pops=%0d expected at least 300", npops);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_stream();
        test_stall_drain();
        test_redirect();
        test_align_back_to_back();
        test_wrap();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_unit.md
Name: instr_prefetch_unit

Overview:
Parametrised instruction fetch stage that replaces the single-register PC/fetch pair with a prefetching front end. It owns the fetch PC and issues sequential reads to a synchronous instruction memory with a fixed 1-cycle read latency. Returned words go into a DEPTH-entry FIFO, which presents {pc, instr} to decode through a valid/ready handshake. A branch/jump redirect flushes the FIFO, squashes any in-flight read and restarts fetch at a new PC.

Parameters:
ADDR_W, 32, width of PC and memory address
DATA_W, 32, instruction width
DEPTH, 4, prefetch FIFO entries; power of two, 2..16
RESET_PC, 0, fetch PC after reset
PC_STEP, 4, byte increment between sequential fetches

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
mem_req  out  1  read strobe to instruction memory
mem_addr  out  ADDR_W  read address; valid when mem_req=1
mem_rdata  in  DATA_W  read data; valid in the cycle after the matching mem_req
redirect_valid  in  1  branch/jump taken; flush and restart
redirect_pc  in  ADDR_W  new fetch PC; low log2(PC_STEP) bits are forced to 0
instr_valid  out  1  FIFO head is valid
instr_ready  in  1  decode accepts the head
instr  out  DATA_W  head instruction
instr_pc  out  ADDR_W  PC of the head instruction
fifo_count  out  clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (asynchronous, immediate):
  - fetch_pc=RESET_PC; FIFO empty; in-flight flag=0.
  - mem_req=0, instr_valid=0, fifo_count=0, instr=0, instr_pc=0.
- Issue rule, cycle T:
  - mem_req = !rst && !redirect_valid && (fifo_count + inflight < DEPTH), with one slot credited back if a pop occurs in cycle T.
  - mem_addr = fetch_pc.
  - On issue: fetch_pc <= fetch_pc + PC_STEP, wrapping modulo 2^ADDR_W; inflight <= 1 and tag_pc <= fetch_pc.
  - No issue: inflight <= 0.
- Return, cycle T+1: if inflight and not squashed, {tag_pc, mem_rdata} is pushed at the end of T+1. instr_valid rises in T+2.
- Throughput:
  - 1 instruction/cycle in steady state while instr_ready=1.
  - Credit accounting guarantees a push never hits a full FIFO; an overflow is an assertion failure.
- Output handshake:
  - instr_valid = (fifo_count != 0) && !redirect_valid.
  - A pop occurs when instr_valid && instr_ready.
  - instr and instr_pc stay stable while instr_valid=1 and instr_ready=0.
- Simultaneous push and pop: fifo_count is unchanged; FIFO order is preserved.
- Redirect, cycle R:
  - FIFO cleared (fifo_count=0 in R+1); no pop takes effect in R.
  - Any read issued in R-1 is squashed; its data in R is dropped.
  - fetch_pc <= aligned redirect_pc; mem_req=0 in R.
  - First request at R+1 with mem_addr=redirect_pc; instr_valid first in R+3.
  - A redirect asserted in consecutive cycles uses the last redirect_pc.
- Post-reset latency: first mem_req in the first cycle with rst=0; first instr_valid two cycles later.
- Full FIFO with instr_ready=0: mem_req stays 0 and fetch_pc holds. Fetch resumes in the same cycle the first pop occurs.
- Reset during an in-flight read: the read is discarded. The memory's later mem_rdata is ignored because inflight=0.
- Memory has no backpressure; mem_rdata is sampled only in the cycle following an issued mem_req.

Test Plan:
- Reset release, memory word[i]=0x1000+i, instr_ready=1 → mem_addr 0,4,8,... on consecutive cycles; instr_valid from cycle 2; stream instr_pc=0,4,8 with instr=0x1000,0x1001,0x1002, one per cycle.
- instr_ready=0 after reset → fifo_count climbs to 4 and holds; mem_req=0 once 4 entries are fetched or in flight; the head stays instr_pc=0. Raising instr_ready then drains 0,4,8,12,16 with no gap or duplicate.
- Redirect to 0x40 while FIFO holds 3 entries and a read is in flight → instr_valid=0 in R; fifo_count=0 in R+1; mem_addr=0x40 at R+1; instr_pc=0x40 at R+3; no stale entry is ever presented.
- redirect_pc=0x43 → fetch starts at 0x40; back-to-back redirects 0x80 then 0xC0 → only 0xC0 is fetched.
- fetch_pc near 2^ADDR_W-4 (RESET_PC=0xFFFFFFFC) → fetches 0xFFFFFFFC then 0x00000000; the wrap appears in instr_pc.
- rst asserted mid-stream with a read in flight → outputs clear asynchronously; the stale mem_rdata after release is not enqueued; refetch restarts at RESET_PC.
